movwide_decode: RTL

//  Upstream issue stage for the MOVZ/MOVK wide-immediate datapath.
//  - Accepts LEGv8 IW-format instruction words over a valid/ready handshake.
//  - Decodes opcode, hw, imm16 and Rd.
//  - For MOVK, fetches the old Rd value from the register file.
//  - Presents data/fixed/shamt/clear to the transposer, holding them stable

---
 rtl/movwide_decode.sv | 136 +++++++++++++
 1 files changed

// File: rtl/movwide_decode.sv
// MOVZ/MOVK issue stage: decodes LEGv8 IW words, fetches the old Rd for MOVK, holds results for the transposer.
// Optional writeback bypass enabled by defining MOVW_FWD_EN.
module movwide_decode #(
    parameter logic [8:0] OPC_MOVZ = 9'b110100101,
    parameter logic [8:0] OPC_MOVK = 9'b111100101,
    parameter logic [4:0] XZR_IDX  = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        rf_rd_en,
    output logic [4:0]  rf_rd_addr,
    input  logic [63:0] rf_rd_data,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data,
    output logic [15:0] fixed,
    output logic [1:0]  shamt,
    output logic        clear,
    output logic [4:0]  rd,
    output logic        err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RDREG = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] data_q, data_d;
    logic [15:0] fixed_q, fixed_d;
    logic [1:0]  shamt_q, shamt_d;
    logic        clear_q, clear_d;
    logic [4:0]  rd_q, rd_d;
    logic        err_q, err_d;

    logic [8:0] in_opc;
    logic [4:0] in_rd;
    logic       is_movz, is_movk;
    logic       fwd_accept, fwd_rdreg;

    assign in_opc  = instr[31:23];
    assign in_rd   = instr[4:0];
    assign is_movz = (in_opc == OPC_MOVZ);
    assign is_movk = (in_opc == OPC_MOVK);

`ifdef MOVW_FWD_EN
    assign fwd_accept = wb_valid && (wb_rd == in_rd) && (wb_rd != XZR_IDX);
    assign fwd_rdreg  = wb_valid && (wb_rd == rd_q) && (wb_rd != XZR_IDX);
`else
    // Bypass disabled: the register file must provide write-before-read.
    logic unused_wb;
    assign unused_wb  = ^{wb_valid, wb_rd};
    assign fwd_accept = 1'b0;
    assign fwd_rdreg  = 1'b0;
`endif

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == HOLD);
    assign rf_rd_en   = (state_q == IDLE) && in_valid && is_movk && (in_rd != XZR_IDX)
                        && !fwd_accept;
    assign rf_rd_addr = in_rd;
    assign data       = data_q;
    assign fixed      = fixed_q;
    assign shamt      = shamt_q;
    assign clear      = clear_q;
    assign rd         = rd_q;
    assign err        = err_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        fixed_d = fixed_q;
        shamt_d = shamt_q;
        clear_d = clear_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_movz || is_movk) begin
                        fixed_d = instr[20:5];
                        shamt_d = instr[22:21];
                        rd_d    = in_rd;
                        clear_d = is_movz;
                        if (is_movz || (in_rd == XZR_IDX)) begin
                            data_d  = 64'd0;
                            state_d = HOLD;
                        end else if (fwd_accept) begin
                            data_d  = wb_data;
                            state_d = HOLD;
                        end else begin
                            state_d = RDREG;
                        end
                    end else begin
                        // Illegal opcode is consumed; only err reports it.
                        err_d = 1'b1;
                    end
                end
            end
            RDREG: begin
                data_d  = fwd_rdreg ? wb_data : rf_rd_data;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= 64'd0;
            fixed_q <= 16'd0;
            shamt_q <= 2'd0;
            clear_q <= 1'b0;
            rd_q    <= 5'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            fixed_q <= fixed_d;
            shamt_q <= shamt_d;
            clear_q <= clear_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

endmodule
